// File: rtl/fft_pkg.sv
// Shared FFT constants and types: bin count, power width and the tracker state encoding.
package fft_pkg;

    localparam int unsigned NBINS = 8;
    localparam int unsigned BIN_W = 8;
    localparam int unsigned IDX_W = 3;

    typedef logic [IDX_W-1:0] bin_idx_t;
    typedef logic [BIN_W-1:0] bin_pow_t;

    typedef enum logic {IDLE, COLLECT} state_e;

    localparam bin_idx_t LAST_IDX = bin_idx_t'(NBINS - 1);

endpackage

// File: rtl/ema_update.sv
// Shared exponential-average datapath: avg + ((new - avg) >>> AVG_SHIFT), or new when priming.
module ema_update
    import fft_pkg::*;
#(
    parameter int unsigned AVG_SHIFT = 2
) (
    input  logic [BIN_W-1:0] old_pow,
    input  logic [BIN_W-1:0] new_pow,
    input  logic             prime,
    output logic [BIN_W-1:0] avg
);

    logic signed [BIN_W:0] diff;
    logic signed [BIN_W:0] step;
    logic signed [BIN_W:0] sum;

    // One extra bit holds the signed difference; the sum always lands back in 0..2^BIN_W-1.
    always_comb begin
        diff = $signed({1'b0, new_pow}) - $signed({1'b0, old_pow});
        step = diff >>> AVG_SHIFT;
        sum  = $signed({1'b0, old_pow}) + step;
        avg  = prime ? new_pow : bin_pow_t'(sum);
    end

endmodule

// File: rtl/fft_peak_tracker.sv
// Averages the serial per-bin power stream and reports the strongest bin once per frame,
// with a hysteretic tone-detect flag.
module fft_peak_tracker
    import fft_pkg::*;
#(
    parameter int unsigned AVG_SHIFT = 2,
    parameter bit          SKIP_DC   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bin_valid,
    input  logic [IDX_W-1:0] bin_idx,
    input  logic [BIN_W-1:0] bin_pow,
    input  logic [BIN_W-1:0] thr_on,
    input  logic [BIN_W-1:0] thr_off,
    output logic             peak_valid,
    output logic [IDX_W-1:0] peak_idx,
    output logic [BIN_W-1:0] peak_pow,
    output logic             detect,
    output logic             frame_err,
    output logic [7:0]       frame_cnt
);

    state_e   state_q, state_d;
    bin_idx_t exp_q, exp_d;
    bin_pow_t avg_q [NBINS];
    logic     prime_q;

    bin_idx_t best_idx_q, best_idx_d;
    bin_pow_t best_pow_q, best_pow_d;
    logic     best_valid_q, best_valid_d;

    bin_idx_t peak_idx_q;
    bin_pow_t peak_pow_q;
    logic     detect_q;
    logic     peak_valid_q;
    logic     frame_err_q;
    logic [7:0] frame_cnt_q;

    logic     beat;
    logic     accept;
    logic     seq_err;
    logic     last;
    bin_pow_t ema_avg;

    assign beat = ena & bin_valid;

    ema_update #(
        .AVG_SHIFT (AVG_SHIFT)
    ) u_ema (
        .old_pow (avg_q[bin_idx]),
        .new_pow (bin_pow),
        .prime   (prime_q),
        .avg     (ema_avg)
    );

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        accept       = 1'b0;
        seq_err      = 1'b0;
        best_idx_d   = best_idx_q;
        best_pow_d   = best_pow_q;
        best_valid_d = best_valid_q;

        if (beat) begin
            case (state_q)
                IDLE:    accept = (bin_idx == '0);
                COLLECT: begin
                    if (bin_idx == exp_q) begin
                        accept = 1'b1;
                    end else begin
                        seq_err = 1'b1;
                        // A stray bin 0 is taken as the start of a fresh frame.
                        accept  = (bin_idx == '0);
                        if (!accept) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        last = accept && (bin_idx == LAST_IDX);

        if (accept) begin
            exp_d   = bin_idx + 1'b1;
            state_d = last ? IDLE : COLLECT;
            if (bin_idx == '0) begin
                best_valid_d = !SKIP_DC;
                best_idx_d   = '0;
                best_pow_d   = SKIP_DC ? '0 : ema_avg;
            end else if (!best_valid_q || ema_avg > best_pow_q) begin
                best_valid_d = 1'b1;
                best_idx_d   = bin_idx;
                best_pow_d   = ema_avg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            prime_q      <= 1'b1;
            best_idx_q   <= '0;
            best_pow_q   <= '0;
            best_valid_q <= 1'b0;
            peak_idx_q   <= '0;
            peak_pow_q   <= '0;
            detect_q     <= 1'b0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
            for (int i = 0; i < NBINS; i++) avg_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            best_idx_q   <= best_idx_d;
            best_pow_q   <= best_pow_d;
            best_valid_q <= best_valid_d;
            peak_valid_q <= last;
            frame_err_q  <= seq_err;
            if (accept) avg_q[bin_idx] <= ema_avg;
            if (last) begin
                peak_idx_q  <= best_idx_d;
                peak_pow_q  <= best_pow_d;
                frame_cnt_q <= frame_cnt_q + 8'd1;
                prime_q     <= 1'b0;
                if (best_pow_d >= thr_on) detect_q <= 1'b1;
                else if (best_pow_d < thr_off) detect_q <= 1'b0;
            end
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_idx   = peak_idx_q;
    assign peak_pow   = peak_pow_q;
    assign detect     = detect_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Bench for fft_peak_tracker: two instances (AVG_SHIFT 2 and 0) share stimulus and are checked
// against a frame-level reference model.
module tb_fft_peak_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       bin_valid = 1'b0;
    logic [2:0] bin_idx = '0;
    logic [7:0] bin_pow = '0;
    logic [7:0] thr_on = 8'd255;
    logic [7:0] thr_off = 8'd0;

    logic [1:0] pv, fe, det;
    logic [2:0] pidx [2];
    logic [7:0] ppow [2];
    logic [7:0] fcnt [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = AVG_SHIFT 2, index 1 = AVG_SHIFT 0.
    int sh [2] = '{2, 0};
    int m_avg [2][8];
    bit m_prime [2];
    bit m_busy [2];
    int m_next [2];
    int e_pv [2], e_fe [2], e_pidx [2], e_ppow [2], e_det [2], e_fcnt [2];

    always #5 clk = ~clk;

    fft_peak_tracker #(.AVG_SHIFT(2), .SKIP_DC(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .bin_pow(bin_pow), .thr_on(thr_on), .thr_off(thr_off), .peak_valid(pv[0]),
        .peak_idx(pidx[0]), .peak_pow(ppow[0]), .detect(det[0]), .frame_err(fe[0]),
        .frame_cnt(fcnt[0])
    );

    fft_peak_tracker #(.AVG_SHIFT(0), .SKIP_DC(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .bin_pow(bin_pow), .thr_on(thr_on), .thr_off(thr_off), .peak_valid(pv[1]),
        .peak_idx(pidx[1]), .peak_pow(ppow[1]), .detect(det[1]), .frame_err(fe[1]),
        .frame_cnt(fcnt[1])
    );

    // Applies the rules to the inputs seen at one clock edge.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            bit take;
            int bp, bi;
            e_pv[m] = 0;
            e_fe[m] = 0;
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) m_avg[m][k] = 0;
                m_prime[m] = 1; m_busy[m] = 0; m_next[m] = 0;
                e_pidx[m] = 0; e_ppow[m] = 0; e_det[m] = 0; e_fcnt[m] = 0;
            end else if (ena && bin_valid) begin
                take = 0;
                if (!m_busy[m]) take = (bin_idx == 0);
                else if (int'(bin_idx) == m_next[m]) take = 1;
                else begin
                    e_fe[m] = 1;
                    m_busy[m] = 0;
                    take = (bin_idx == 0);
                end
                if (take) begin
                    if (m_prime[m]) m_avg[m][bin_idx] = int'(bin_pow);
                    else m_avg[m][bin_idx] = m_avg[m][bin_idx]
                        + ((int'(bin_pow) - m_avg[m][bin_idx]) >>> sh[m]);
                    m_busy[m] = 1;
                    m_next[m] = int'(bin_idx) + 1;
                    if (bin_idx == 7) begin
                        m_busy[m] = 0;
                        bp = -1; bi = 0;
                        for (int k = 1; k < 8; k++)
                            if (m_avg[m][k] > bp) begin bp = m_avg[m][k]; bi = k; end
                        e_pidx[m] = bi;
                        e_ppow[m] = bp;
                        e_fcnt[m] = (e_fcnt[m] + 1) % 256;
                        m_prime[m] = 0;
                        if (bp >= int'(thr_on)) e_det[m] = 1;
                        else if (bp < int'(thr_off)) e_det[m] = 0;
                        e_pv[m] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit v, input int idx, input int pow);
        bin_valid = v;
        bin_idx = 3'(idx);
        bin_pow = 8'(pow);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_frame(input int p0, input int p1, input int p2, input int p3,
                              input int p4, input int p5, input int p6, input int p7);
        int p [8];
        p = '{p0, p1, p2, p3, p4, p5, p6, p7};
        for (int i = 0; i < 8; i++) step(1, i, p[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(0, 0, 0);
        step(1, 0, 99);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({pv[m], fe[m], pidx[m], ppow[m], det[m], fcnt[m]} !== 22'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got pv=%0d fe=%0d idx=%0d pow=%0d det=%0d cnt=%0d, expected all 0",
                         m, pv[m], fe[m], pidx[m], ppow[m], det[m], fcnt[m]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frames();
        thr_on = 8'd255; thr_off = 8'd0;
        step(0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, i, (i == 1) ? 10 : (i == 2) ? 200 : (i == 3) ? 30 : 0);
            checks++;
            if (pv[0] !== 1'b0) begin
                errors++; $display("FAIL early_peak_valid: got %0d expected 0 at bin %0d", pv[0], i);
            end
        end
        step(1, 7, 0);
        checks++;
        if (pv[0] !== 1'b1 || pidx[0] !== 3'd2 || ppow[0] !== 8'd200 || fcnt[0] !== 8'd1) begin
            errors++;
            $display("FAIL frame1: got pv=%0d idx=%0d pow=%0d cnt=%0d expected 1 2 200 1",
                     pv[0], pidx[0], ppow[0], fcnt[0]);
        end
        step(0, 0, 0);
        checks++;
        if (pv[0] !== 1'b0) begin
            errors++; $display("FAIL pulse_width: got %0d expected 0", pv[0]);
        end
        send_frame(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pv[0] !== 1'b1 || pidx[0] !== 3'd2 || ppow[0] !== 8'd150 || fcnt[0] !== 8'd2) begin
            errors++;
            $display("FAIL frame2_ema: got pv=%0d idx=%0d pow=%0d cnt=%0d expected 1 2 150 2",
                     pv[0], pidx[0], ppow[0], fcnt[0]);
        end
        checks++;
        if (pidx[1] !== 3'(e_pidx[1]) || ppow[1] !== 8'(e_ppow[1])) begin
            errors++;
            $display("FAIL frame2_noavg: got idx=%0d pow=%0d expected %0d %0d",
                     pidx[1], ppow[1], e_pidx[1], e_ppow[1]);
        end
    endtask

    task automatic test_skip_dc();
        rst_n = 1'b0; step(0, 0, 0); rst_n = 1'b1;
        send_frame(255, 50, 50, 0, 0, 0, 0, 0);
        checks++;
        if (pidx[0] !== 3'd1 || ppow[0] !== 8'd50 || fcnt[0] !== 8'd1) begin
            errors++;
            $display("FAIL skip_dc_tie: got idx=%0d pow=%0d cnt=%0d expected 1 50 1",
                     pidx[0], ppow[0], fcnt[0]);
        end
    endtask

    task automatic test_seq_err();
        int cnt0;
        cnt0 = int'(fcnt[0]);
        step(1, 0, 5); step(1, 1, 5); step(1, 2, 5);
        step(1, 5, 5);
        checks++;
        if (fe[0] !== 1'b1 || pv[0] !== 1'b0) begin
            errors++; $display("FAIL seq_err_pulse: got fe=%0d pv=%0d expected 1 0", fe[0], pv[0]);
        end
        step(0, 0, 0);
        checks++;
        if (fe[0] !== 1'b0 || fcnt[0] !== 8'(cnt0)) begin
            errors++;
            $display("FAIL seq_err_drop: got fe=%0d cnt=%0d expected 0 %0d", fe[0], fcnt[0], cnt0);
        end
        // Stray beats in idle are silently ignored.
        step(1, 6, 9);
        checks++;
        if (fe[0] !== 1'b0) begin
            errors++; $display("FAIL idle_stray: got fe=%0d expected 0", fe[0]);
        end
        send_frame(1, 2, 3, 4, 90, 6, 7, 8);
        checks++;
        if (pv[0] !== 1'b1 || fcnt[0] !== 8'(cnt0 + 1) || ppow[0] !== 8'(e_ppow[0])
            || pidx[0] !== 3'(e_pidx[0])) begin
            errors++;
            $display("FAIL clean_after_err: got pv=%0d cnt=%0d idx=%0d pow=%0d expected 1 %0d %0d %0d",
                     pv[0], fcnt[0], pidx[0], ppow[0], cnt0 + 1, e_pidx[0], e_ppow[0]);
        end
        step(1, 0, 1); step(1, 1, 1); step(1, 0, 1);
        checks++;
        if (fe[0] !== 1'b1) begin
            errors++; $display("FAIL restart_err: got fe=%0d expected 1", fe[0]);
        end
        for (int i = 1; i < 8; i++) step(1, i, 3);
        checks++;
        if (pv[0] !== 1'b1 || fcnt[0] !== 8'(cnt0 + 2)) begin
            errors++;
            $display("FAIL restart_complete: got pv=%0d cnt=%0d expected 1 %0d", pv[0], fcnt[0], cnt0 + 2);
        end
    endtask

    task automatic test_back_to_back();
        int peaks [3] = '{120, 70, 40};
        int want [3] = '{1, 1, 0};
        thr_on = 8'd100; thr_off = 8'd50;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                step(1, i, (i == 3) ? peaks[f] : 0);
                if (i == 0 && f > 0) begin
                    checks++;
                    if (pv[1] !== 1'b0) begin
                        errors++; $display("FAIL b2b_pulse_end: got %0d expected 0", pv[1]);
                    end
                end
            end
            checks++;
            if (pv[1] !== 1'b1 || det[1] !== 1'(want[f]) || ppow[1] !== 8'(peaks[f])) begin
                errors++;
                $display("FAIL detect_f%0d: got pv=%0d det=%0d pow=%0d expected 1 %0d %0d",
                         f, pv[1], det[1], ppow[1], want[f], peaks[f]);
            end
            checks++;
            if (det[0] !== 1'(e_det[0]) || ppow[0] !== 8'(e_ppow[0])) begin
                errors++;
                $display("FAIL detect_avg_f%0d: got det=%0d pow=%0d expected %0d %0d",
                         f, det[0], ppow[0], e_det[0], e_ppow[0]);
            end
        end
    endtask

    task automatic test_ena();
        int cnt0;
        thr_on = 8'd255; thr_off = 8'd0;
        step(0, 0, 0);
        cnt0 = int'(fcnt[0]);
        step(1, 0, 1); step(1, 1, 2); step(1, 2, 3);
        ena = 1'b0;
        for (int i = 3; i < 8; i++) begin
            step(1, (i == 5) ? 0 : i, 250);
            checks++;
            if (pv !== 2'b00 || fe !== 2'b00 || fcnt[0] !== 8'(cnt0)) begin
                errors++;
                $display("FAIL ena_freeze: got pv=%0d fe=%0d cnt=%0d expected 0 0 %0d",
                         pv, fe, fcnt[0], cnt0);
            end
        end
        ena = 1'b1;
        for (int i = 3; i < 8; i++) step(1, i, 4);
        checks++;
        if (pv[0] !== 1'b1 || fcnt[0] !== 8'(cnt0 + 1) || ppow[0] !== 8'(e_ppow[0])) begin
            errors++;
            $display("FAIL ena_resume: got pv=%0d cnt=%0d pow=%0d expected 1 %0d %0d",
                     pv[0], fcnt[0], ppow[0], cnt0 + 1, e_ppow[0]);
        end
        step(1, 0, 9); step(1, 1, 9);
        rst_n = 1'b0;
        step(1, 2, 9);
        rst_n = 1'b1;
        checks++;
        if ({pv[0], fe[0], pidx[0], ppow[0], det[0], fcnt[0]} !== 22'd0) begin
            errors++;
            $display("FAIL midframe_reset: got idx=%0d pow=%0d cnt=%0d expected 0 0 0",
                     pidx[0], ppow[0], fcnt[0]);
        end
        // Bin 2 was averaged before; after reset the first frame must load raw values.
        send_frame(0, 5, 6, 0, 0, 77, 0, 0);
        checks++;
        if (pidx[0] !== 3'd5 || ppow[0] !== 8'd77 || fcnt[0] !== 8'd1) begin
            errors++;
            $display("FAIL primed_after_reset: got idx=%0d pow=%0d cnt=%0d expected 5 77 1",
                     pidx[0], ppow[0], fcnt[0]);
        end
    endtask

    task automatic test_random();
        int seq = 0;
        int idx;
        thr_on = 8'($urandom_range(40, 200));
        thr_off = 8'($urandom_range(20, 160));
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 7) begin
                idx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : seq;
                seq = (seq + 1) % 8;
                step(1, idx, int'($urandom_range(0, 255)));
            end else begin
                step(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            end
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (pv[m] !== 1'(e_pv[m]) || fe[m] !== 1'(e_fe[m]) || pidx[m] !== 3'(e_pidx[m])
                    || ppow[m] !== 8'(e_ppow[m]) || det[m] !== 1'(e_det[m])
                    || fcnt[m] !== 8'(e_fcnt[m])) begin
                    errors++;
                    $display("FAIL random[%0d] c=%0d: got pv=%0d fe=%0d idx=%0d pow=%0d det=%0d cnt=%0d expected %0d %0d %0d %0d %0d %0d",
                             m, c, pv[m], fe[m], pidx[m], ppow[m], det[m], fcnt[m],
                             e_pv[m], e_fe[m], e_pidx[m], e_ppow[m], e_det[m], e_fcnt[m]);
                end
            end
        end
        rst_n = 1'b1;
        ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_skip_dc();
        test_seq_err();
        test_back_to_back();
        test_ena();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
